// File: rtl/cva6_lsu_port_arbiter.sv
// Shares one data-memory port between the load path and the store-drain path.
// One transaction is in flight at a time. Each transaction runs a request/grant
// phase and then a wait-for-response phase. A load that aliases a pending store
// is held back. A waiting store wins after STARVE_MAX consecutive load grants.
module cva6_lsu_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned TO_W       = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_gnt_o,
  output logic              ld_stall_o,
  output logic              ld_done_o,
  input  logic              st_pending_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic              st_match_i,
  output logic              st_gnt_o,
  output logic              st_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_resp_i,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_WAIT,
    ST_REQ,
    ST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ld_done_q, ld_done_d;
  logic              st_done_q, st_done_d;
  logic              err_q, err_d;
  logic              ld_gnt, st_gnt;

  // Next-state, grant decision and next values of the registered datapath
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    to_d      = to_q;
    addr_d    = addr_q;
    ld_done_d = 1'b0;
    st_done_d = 1'b0;
    err_d     = err_q;
    ld_gnt    = 1'b0;
    st_gnt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!st_pending_i) begin
          starve_d = '0;
        end
        if (st_pending_i && (!ld_req_i || st_match_i || (starve_q == STARVE_LIM))) begin
          st_gnt   = 1'b1;
          state_d  = ST_REQ;
          addr_d   = st_addr_i;
          starve_d = '0;
        end else if (ld_req_i && !st_match_i) begin
          ld_gnt  = 1'b1;
          state_d = LD_REQ;
          addr_d  = ld_addr_i;
          if (st_pending_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      LD_REQ, ST_REQ: begin
        if (mem_gnt_i) begin
          state_d = (state_q == LD_REQ) ? LD_WAIT : ST_WAIT;
          to_d    = '0;
        end
      end
      LD_WAIT, ST_WAIT: begin
        if (mem_resp_i) begin
          ld_done_d = (state_q == LD_WAIT);
          st_done_d = (state_q == ST_WAIT);
          state_d   = IDLE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      to_q      <= '0;
      addr_q    <= '0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      to_q      <= to_d;
      addr_q    <= addr_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      err_q     <= err_d;
    end
  end

  assign ld_gnt_o   = ld_gnt & ~rst_i;
  assign st_gnt_o   = st_gnt & ~rst_i;
  assign ld_stall_o = ld_req_i & st_match_i;
  assign ld_done_o  = ld_done_q;
  assign st_done_o  = st_done_q;
  assign mem_req_o  = (state_q == LD_REQ) || (state_q == ST_REQ);
  assign mem_we_o   = (state_q == ST_REQ);
  assign mem_addr_o = addr_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_cva6_lsu_port_arbiter.sv
// Bench for cva6_lsu_port_arbiter. A transaction-level model is compared against
// the design on every cycle. Directed scenarios add literal checks at key cycles.
module tb_cva6_lsu_port_arbiter;

  localparam int AW   = 12;
  localparam int SMAX = 4;
  localparam int TMO  = 15;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          ld_req_i;
  logic [AW-1:0] ld_addr_i;
  logic          ld_gnt_o;
  logic          ld_stall_o;
  logic          ld_done_o;
  logic          st_pending_i;
  logic [AW-1:0] st_addr_i;
  logic          st_match_i;
  logic          st_gnt_o;
  logic          st_done_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_resp_i;
  logic          err_o;

  int n_vec = 0;
  int n_err = 0;

  cva6_lsu_port_arbiter #(
    .ADDR_W(12), .STARVE_MAX(4), .CNT_W(3), .TIMEOUT(15), .TO_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_gnt_o(ld_gnt_o),
    .ld_stall_o(ld_stall_o), .ld_done_o(ld_done_o),
    .st_pending_i(st_pending_i), .st_addr_i(st_addr_i), .st_match_i(st_match_i),
    .st_gnt_o(st_gnt_o), .st_done_o(st_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_resp_i(mem_resp_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which transaction is open, whether memory accepted it,
  // how long it has waited, and the starvation tally.
  int            m_kind;
  bit            m_acc;
  int            m_wait;
  int            m_starve;
  bit            m_err;
  bit            m_ldd;
  bit            m_std;
  logic [AW-1:0] m_addr;
  bit            want_st;
  bit            want_ld;

  // Compare DUT against the model each cycle, then advance the model
  initial begin
    m_kind = 0; m_acc = 0; m_wait = 0; m_starve = 0;
    m_err = 0; m_ldd = 0; m_std = 0; m_addr = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      want_st = !rst_i && m_kind == 0 && st_pending_i &&
                (!ld_req_i || st_match_i || m_starve >= SMAX);
      want_ld = !rst_i && m_kind == 0 && !want_st && ld_req_i && !st_match_i;
      chk1("m.ld_gnt",   ld_gnt_o,   want_ld);
      chk1("m.st_gnt",   st_gnt_o,   want_st);
      chk1("m.ld_stall", ld_stall_o, ld_req_i && st_match_i);
      chk1("m.mem_req",  mem_req_o,  m_kind != 0 && !m_acc);
      chk1("m.mem_we",   mem_we_o,   m_kind == 2 && !m_acc);
      chk1("m.ld_done",  ld_done_o,  m_ldd);
      chk1("m.st_done",  st_done_o,  m_std);
      chk1("m.err",      err_o,      m_err);
      chka("m.mem_addr", mem_addr_o, m_addr);
      if (rst_i) begin
        m_kind = 0; m_acc = 0; m_wait = 0; m_starve = 0;
        m_err = 0; m_ldd = 0; m_std = 0; m_addr = '0;
      end else begin
        m_ldd = 0;
        m_std = 0;
        if (m_kind == 0) begin
          if (want_st) begin
            m_kind = 2; m_acc = 0; m_addr = st_addr_i; m_starve = 0;
          end else if (want_ld) begin
            m_kind = 1; m_acc = 0; m_addr = ld_addr_i;
            m_starve = st_pending_i ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
          end else if (!st_pending_i) begin
            m_starve = 0;
          end
        end else if (!m_acc) begin
          if (mem_gnt_i) begin
            m_acc = 1; m_wait = 0;
          end
        end else begin
          m_wait++;
          if (mem_resp_i) begin
            if (m_kind == 1) m_ldd = 1; else m_std = 1;
            m_kind = 0;
          end else if (m_wait == TMO) begin
            m_err = 1; m_kind = 0;
          end
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // From the first WAIT cycle: respond in wait cycle rd, end on the done cycle
  task automatic finish_from_wait(input int rd);
    repeat (rd - 1) nxt();
    mem_resp_i = 1'b1;
    nxt();
    mem_resp_i = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    rst_i = 1'b1; ld_req_i = 1'b0; ld_addr_i = '0; st_pending_i = 1'b0;
    st_addr_i = '0; st_match_i = 1'b0; mem_gnt_i = 1'b0; mem_resp_i = 1'b0;
    nxt(); nxt();
    look();
    chk1("t1.ld_gnt", ld_gnt_o, 1'b0);   chk1("t1.st_gnt", st_gnt_o, 1'b0);
    chk1("t1.ld_done", ld_done_o, 1'b0); chk1("t1.st_done", st_done_o, 1'b0);
    chk1("t1.mem_req", mem_req_o, 1'b0); chk1("t1.mem_we", mem_we_o, 1'b0);
    chk1("t1.err", err_o, 1'b0);         chk1("t1.ld_stall", ld_stall_o, 1'b0);
    chka("t1.mem_addr", mem_addr_o, 12'h000);
    nxt();
    rst_i = 1'b0;
    nxt();

    // Lone load
    ld_req_i = 1'b1; ld_addr_i = 12'h0A8;
    look(); chk1("t2.ld_gnt", ld_gnt_o, 1'b1); nxt();
    ld_req_i = 1'b0;
    look(); chk1("t2.mem_req1", mem_req_o, 1'b1); chk1("t2.mem_we", mem_we_o, 1'b0);
    chka("t2.mem_addr", mem_addr_o, 12'h0A8); nxt();
    mem_gnt_i = 1'b1;
    look(); chk1("t2.mem_req2", mem_req_o, 1'b1); nxt();
    mem_gnt_i = 1'b0;
    look(); chk1("t2.mem_req_wait", mem_req_o, 1'b0); nxt();
    mem_resp_i = 1'b1;
    look(); chk1("t2.no_early_done", ld_done_o, 1'b0); nxt();
    mem_resp_i = 1'b0;
    look(); chk1("t2.ld_done", ld_done_o, 1'b1); nxt();
    look(); chk1("t2.ld_done_pulse", ld_done_o, 1'b0); nxt();

    // Reset while in LD_WAIT
    ld_req_i = 1'b1; ld_addr_i = 12'h123; nxt();
    ld_req_i = 1'b0; mem_gnt_i = 1'b1; nxt();
    mem_gnt_i = 1'b0; rst_i = 1'b1;
    look(); chk1("t1b.wait_req", mem_req_o, 1'b0); nxt();
    rst_i = 1'b0; mem_resp_i = 1'b1;
    look(); chk1("t1b.ld_done", ld_done_o, 1'b0); chk1("t1b.mem_req", mem_req_o, 1'b0);
    chka("t1b.mem_addr", mem_addr_o, 12'h000); nxt();
    mem_resp_i = 1'b0;
    look(); chk1("t1b.ld_done2", ld_done_o, 1'b0); nxt();

    // Aliasing load waits behind the store
    st_pending_i = 1'b1; st_addr_i = 12'h3F0; ld_req_i = 1'b1; ld_addr_i = 12'h3F4;
    st_match_i = 1'b1;
    look(); chk1("t3.stall", ld_stall_o, 1'b1); chk1("t3.st_gnt", st_gnt_o, 1'b1);
    chk1("t3.ld_gnt", ld_gnt_o, 1'b0); nxt();
    st_pending_i = 1'b0; mem_gnt_i = 1'b1;
    look(); chk1("t3.mem_we", mem_we_o, 1'b1); chka("t3.mem_addr", mem_addr_o, 12'h3F0);
    chk1("t3.stall2", ld_stall_o, 1'b1); nxt();
    mem_gnt_i = 1'b0;
    finish_from_wait(1);
    st_match_i = 1'b0;
    look(); chk1("t3.st_done", st_done_o, 1'b1); chk1("t3.ld_gnt2", ld_gnt_o, 1'b1); nxt();
    ld_req_i = 1'b0; mem_gnt_i = 1'b1;
    look(); chka("t3.ld_addr", mem_addr_o, 12'h3F4); nxt();
    mem_gnt_i = 1'b0;
    finish_from_wait(2);
    look(); chk1("t3.ld_done", ld_done_o, 1'b1); nxt();

    // Starvation bound
    ld_req_i = 1'b1; st_pending_i = 1'b1; st_match_i = 1'b0; st_addr_i = 12'h200;
    for (int i = 0; i < SMAX; i++) begin
      ld_addr_i = AW'(256 + 4 * i);
      look(); chk1("t4.ld_gnt", ld_gnt_o, 1'b1); chk1("t4.st_hold", st_gnt_o, 1'b0); nxt();
      mem_gnt_i = 1'b1; nxt();
      mem_gnt_i = 1'b0;
      finish_from_wait(1);
    end
    look(); chk1("t4.st_gnt", st_gnt_o, 1'b1); chk1("t4.ld_held", ld_gnt_o, 1'b0); nxt();
    mem_gnt_i = 1'b1; nxt();
    mem_gnt_i = 1'b0;
    finish_from_wait(1);
    look(); chk1("t4.restart_ld", ld_gnt_o, 1'b1); chk1("t4.restart_st", st_gnt_o, 1'b0); nxt();
    ld_req_i = 1'b0; st_pending_i = 1'b0; mem_gnt_i = 1'b1; nxt();
    mem_gnt_i = 1'b0;
    finish_from_wait(1);
    nxt();

    // Response on the last allowed wait cycle completes normally
    st_pending_i = 1'b1; st_addr_i = 12'h7FC;
    look(); chk1("t5a.st_gnt", st_gnt_o, 1'b1); nxt();
    st_pending_i = 1'b0; mem_gnt_i = 1'b1; nxt();
    mem_gnt_i = 1'b0;
    finish_from_wait(TMO);
    look(); chk1("t5a.st_done", st_done_o, 1'b1); chk1("t5a.err", err_o, 1'b0); nxt();

    // Timeout in ST_WAIT
    st_pending_i = 1'b1; st_addr_i = 12'h444; nxt();
    st_pending_i = 1'b0; mem_gnt_i = 1'b1; nxt();
    mem_gnt_i = 1'b0;
    repeat (TMO - 1) nxt();
    look(); chk1("t5.err_before", err_o, 1'b0); nxt();
    look(); chk1("t5.err", err_o, 1'b1); chk1("t5.no_done", st_done_o, 1'b0);
    chk1("t5.mem_req", mem_req_o, 1'b0); nxt();
    ld_req_i = 1'b1; ld_addr_i = 12'h055;
    look(); chk1("t5.ld_gnt", ld_gnt_o, 1'b1); nxt();
    ld_req_i = 1'b0; mem_gnt_i = 1'b1; nxt();
    mem_gnt_i = 1'b0;
    finish_from_wait(3);
    look(); chk1("t5.ld_done", ld_done_o, 1'b1); chk1("t5.err_sticky", err_o, 1'b1); nxt();

    // Spurious memory handshakes
    mem_resp_i = 1'b1; mem_gnt_i = 1'b1;
    look(); chk1("t6.idle_req", mem_req_o, 1'b0); nxt();
    mem_resp_i = 1'b0; mem_gnt_i = 1'b0;
    look(); chk1("t6.idle_ld_done", ld_done_o, 1'b0); chk1("t6.idle_st_done", st_done_o, 1'b0); nxt();
    ld_req_i = 1'b1; ld_addr_i = 12'h0F0;
    look(); chk1("t6.ld_gnt", ld_gnt_o, 1'b1); nxt();
    ld_req_i = 1'b0; mem_resp_i = 1'b1;
    look(); chk1("t6.req_hold", mem_req_o, 1'b1); nxt();
    mem_gnt_i = 1'b1; mem_resp_i = 1'b1;
    look(); chk1("t6.req_hold2", mem_req_o, 1'b1); chk1("t6.no_done_req", ld_done_o, 1'b0); nxt();
    mem_resp_i = 1'b0;
    look(); chk1("t6.wait_req", mem_req_o, 1'b0); chk1("t6.resp_ignored", ld_done_o, 1'b0); nxt();
    look(); chk1("t6.gnt_in_wait", ld_done_o, 1'b0); nxt();
    mem_gnt_i = 1'b0; mem_resp_i = 1'b1; nxt();
    mem_resp_i = 1'b0;
    look(); chk1("t6.ld_done", ld_done_o, 1'b1); nxt();

    repeat (3) nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
